blob_corner_tracker: RTL and testbench

BLOB_CORNER_TRACKER -- requirements
Module: blob_corner_tracker

---
 rtl/blob_corner_tracker.sv | 358 +++++++++++++++++++++++++++++++++++
 tb/tb_blob_corner_tracker.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_corner_tracker.sv
// blob_corner_tracker: per-channel chroma blob tracker that keeps a pixel
// history shift register and publishes four extreme corners per frame.
// Ports: clk, reset (sync, active-high); VGA_VS, pix_valid, pix_x/pix_y,
//   Cb/Cr pixel stream; hist_in/hist_out/we history read-modify-write;
//   cb_lo/cb_hi/cr_lo/cr_hi, hist_thresh per-channel qualification;
//   threshold_x_diff/threshold_y_diff snap tolerance; corner_code per pixel;
//   corner_x/corner_y (TL,TR,BL,BR), pix_count, frame_valid, busy, overrun.
// Option: define CORNER_SNAP_EN to snap near-aligned corners to the bbox.
module blob_corner_tracker #(
  parameter int NUM_CH  = 2,
  parameter int HIST_W  = 4,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COORD_W = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          VGA_VS,
  input  logic                          pix_valid,
  input  logic [COORD_W-1:0]            pix_x,
  input  logic [COORD_W-1:0]            pix_y,
  input  logic [7:0]                    Cb,
  input  logic [7:0]                    Cr,
  input  logic [NUM_CH*HIST_W-1:0]      hist_in,
  input  logic [NUM_CH*8-1:0]           cb_lo,
  input  logic [NUM_CH*8-1:0]           cb_hi,
  input  logic [NUM_CH*8-1:0]           cr_lo,
  input  logic [NUM_CH*8-1:0]           cr_hi,
  input  logic [NUM_CH*4-1:0]           hist_thresh,
  input  logic [7:0]                    threshold_x_diff,
  input  logic [7:0]                    threshold_y_diff,
  output logic [NUM_CH*HIST_W-1:0]      hist_out,
  output logic                          we,
  output logic [NUM_CH*3-1:0]           corner_code,
  output logic [NUM_CH*4*COORD_W-1:0]   corner_x,
  output logic [NUM_CH*4*COORD_W-1:0]   corner_y,
  output logic [NUM_CH*20-1:0]          pix_count,
  output logic                          frame_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);
  localparam logic [IDX_W-1:0] CH_LAST = IDX_W'(NUM_CH - 1);
  localparam logic [19:0] CNT_MAX = '1;
  localparam int TL = 0;
  localparam int TR = 1;
  localparam int BL = 2;
  localparam int BR = 3;

  typedef logic [COORD_W-1:0] coord_t;
  typedef enum logic {S_ACCUM, S_RESOLVE} state_e;

  function automatic logic [4:0] popcnt(input logic [HIST_W-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < HIST_W; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

`ifdef CORNER_SNAP_EN
  function automatic logic near(input coord_t a, input coord_t b,
                                input logic [7:0] t);
    coord_t d;
    d = (a > b) ? a - b : b - a;
    return {8'd0, d} <= {{COORD_W{1'b0}}, t};
  endfunction
`endif

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              fv_q, fv_d;
  logic              vs_prev_q;
  logic              overrun_q;
  logic              vs_fall;
  logic              take;

  logic                       we_q;
  logic [NUM_CH*HIST_W-1:0]   hist_q, hist_d;
  logic [NUM_CH*3-1:0]        code_q, code_d;
  logic [NUM_CH-1:0]          match, qual;
  logic                       in_frame;

  coord_t      xmin_q [NUM_CH];
  coord_t      xmax_q [NUM_CH];
  coord_t      ymin_q [NUM_CH];
  coord_t      ymax_q [NUM_CH];
  coord_t      acc_x_q [NUM_CH][4];
  coord_t      acc_y_q [NUM_CH][4];
  logic [19:0] cnt_q [NUM_CH];

  coord_t      sh_xmin_q [NUM_CH];
  coord_t      sh_xmax_q [NUM_CH];
  coord_t      sh_ymin_q [NUM_CH];
  coord_t      sh_ymax_q [NUM_CH];
  coord_t      sh_x_q [NUM_CH][4];
  coord_t      sh_y_q [NUM_CH][4];
  logic [19:0] sh_cnt_q [NUM_CH];

  coord_t      pub_x_q [NUM_CH][4];
  coord_t      pub_y_q [NUM_CH][4];
  logic [19:0] pub_cnt_q [NUM_CH];

  coord_t      rx [4];
  coord_t      ry [4];
  logic [19:0] rcnt;

  // A falling edge only starts a frame when idle; one seen while
  // resolving is dropped and flagged instead.
  assign vs_fall = vs_prev_q & ~VGA_VS;
  assign take = vs_fall & (state_q == S_ACCUM);

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    fv_d = 1'b0;
    unique case (state_q)
      S_ACCUM: begin
        if (take) begin
          state_d = S_RESOLVE;
          idx_d = '0;
        end
      end
      S_RESOLVE: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == CH_LAST) begin
          state_d = S_ACCUM;
          idx_d = '0;
          fv_d = 1'b1;
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ACCUM;
      idx_q <= '0;
      fv_q <= 1'b0;
      vs_prev_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      fv_q <= fv_d;
      vs_prev_q <= VGA_VS;
      if (vs_fall && state_q == S_RESOLVE) overrun_q <= 1'b1;
    end
  end

  assign in_frame = (pix_x <= X_LAST) && (pix_y <= Y_LAST);

  always_comb begin
    match = '0;
    qual = '0;
    hist_d = '0;
    code_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      match[c] = (Cb >= cb_lo[c*8 +: 8]) && (Cb <= cb_hi[c*8 +: 8]) &&
                 (Cr >= cr_lo[c*8 +: 8]) && (Cr <= cr_hi[c*8 +: 8]);
      qual[c] = match[c] && in_frame &&
                (popcnt(hist_in[c*HIST_W +: HIST_W]) >
                 {1'b0, hist_thresh[c*4 +: 4]});
      hist_d[c*HIST_W +: HIST_W] =
        (hist_in[c*HIST_W +: HIST_W] << 1) | HIST_W'(match[c]);
      if (qual[c]) begin
        if (pix_x == pub_x_q[c][TL] && pix_y == pub_y_q[c][TL])
          code_d[c*3 +: 3] = 3'd1;
        else if (pix_x == pub_x_q[c][TR] && pix_y == pub_y_q[c][TR])
          code_d[c*3 +: 3] = 3'd2;
        else if (pix_x == pub_x_q[c][BL] && pix_y == pub_y_q[c][BL])
          code_d[c*3 +: 3] = 3'd3;
        else if (pix_x == pub_x_q[c][BR] && pix_y == pub_y_q[c][BR])
          code_d[c*3 +: 3] = 3'd4;
        else
          code_d[c*3 +: 3] = 3'd5;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q <= 1'b0;
      hist_q <= '0;
      code_q <= '0;
    end else begin
      we_q <= pix_valid;
      if (pix_valid) begin
        hist_q <= hist_d;
        code_q <= code_d;
      end
    end
  end

  // Bounds start inverted so the first qualified pixel sets all corners.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        xmin_q[c] <= X_LAST;
        xmax_q[c] <= '0;
        ymin_q[c] <= Y_LAST;
        ymax_q[c] <= '0;
        cnt_q[c] <= '0;
        sh_xmin_q[c] <= '0;
        sh_xmax_q[c] <= '0;
        sh_ymin_q[c] <= '0;
        sh_ymax_q[c] <= '0;
        sh_cnt_q[c] <= '0;
        for (int k = 0; k < 4; k++) begin
          acc_x_q[c][k] <= '0;
          acc_y_q[c][k] <= '0;
          sh_x_q[c][k] <= '0;
          sh_y_q[c][k] <= '0;
        end
      end
    end else if (take) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sh_xmin_q[c] <= xmin_q[c];
        sh_xmax_q[c] <= xmax_q[c];
        sh_ymin_q[c] <= ymin_q[c];
        sh_ymax_q[c] <= ymax_q[c];
        sh_cnt_q[c] <= cnt_q[c];
        xmin_q[c] <= X_LAST;
        xmax_q[c] <= '0;
        ymin_q[c] <= Y_LAST;
        ymax_q[c] <= '0;
        cnt_q[c] <= '0;
        for (int k = 0; k < 4; k++) begin
          sh_x_q[c][k] <= acc_x_q[c][k];
          sh_y_q[c][k] <= acc_y_q[c][k];
          acc_x_q[c][k] <= '0;
          acc_y_q[c][k] <= '0;
        end
      end
    end else if (pix_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (qual[c]) begin
          if (pix_x >= xmax_q[c]) begin
            xmax_q[c] <= pix_x;
            acc_x_q[c][BR] <= pix_x;
            acc_y_q[c][BR] <= pix_y;
          end
          if (pix_x <= xmin_q[c]) begin
            xmin_q[c] <= pix_x;
            acc_x_q[c][TL] <= pix_x;
            acc_y_q[c][TL] <= pix_y;
          end
          if (pix_y >= ymax_q[c]) begin
            ymax_q[c] <= pix_y;
            acc_x_q[c][BL] <= pix_x;
            acc_y_q[c][BL] <= pix_y;
          end
          if (pix_y <= ymin_q[c]) begin
            ymin_q[c] <= pix_y;
            acc_x_q[c][TR] <= pix_x;
            acc_y_q[c][TR] <= pix_y;
          end
          if (cnt_q[c] != CNT_MAX) cnt_q[c] <= cnt_q[c] + 20'd1;
        end
      end
    end
  end

  // Corners for the channel being resolved this cycle.
  always_comb begin
    rcnt = sh_cnt_q[idx_q];
    for (int k = 0; k < 4; k++) begin
      rx[k] = sh_x_q[idx_q][k];
      ry[k] = sh_y_q[idx_q][k];
    end
`ifdef CORNER_SNAP_EN
    // Each test sees the result of the previous ones.
    if (near(ry[TL], ry[TR], threshold_y_diff)) begin
      rx[TL] = sh_xmin_q[idx_q];
      ry[TL] = sh_ymin_q[idx_q];
      rx[TR] = sh_xmax_q[idx_q];
      ry[TR] = sh_ymin_q[idx_q];
    end
    if (near(rx[TL], rx[BL], threshold_x_diff)) begin
      rx[TL] = sh_xmin_q[idx_q];
      ry[TL] = sh_ymin_q[idx_q];
      rx[BL] = sh_xmin_q[idx_q];
      ry[BL] = sh_ymax_q[idx_q];
    end
    if (near(ry[BR], ry[BL], threshold_y_diff)) begin
      rx[BR] = sh_xmax_q[idx_q];
      ry[BR] = sh_ymax_q[idx_q];
      rx[BL] = sh_xmin_q[idx_q];
      ry[BL] = sh_ymax_q[idx_q];
    end
    if (near(rx[BR], rx[TR], threshold_x_diff)) begin
      rx[BR] = sh_xmax_q[idx_q];
      ry[BR] = sh_ymax_q[idx_q];
      rx[TR] = sh_xmax_q[idx_q];
      ry[TR] = sh_ymin_q[idx_q];
    end
`endif
    if (rcnt == '0) begin
      for (int k = 0; k < 4; k++) begin
        rx[k] = '0;
        ry[k] = '0;
      end
    end
  end

`ifndef CORNER_SNAP_EN
  // Bounding-box shadows and tolerances only feed the snap logic.
  logic unused_snap;
  always_comb begin
    unused_snap = ^{threshold_x_diff, threshold_y_diff};
    for (int c = 0; c < NUM_CH; c++)
      unused_snap = unused_snap ^
        (^{sh_xmin_q[c], sh_xmax_q[c], sh_ymin_q[c], sh_ymax_q[c]});
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pub_cnt_q[c] <= '0;
        for (int k = 0; k < 4; k++) begin
          pub_x_q[c][k] <= '0;
          pub_y_q[c][k] <= '0;
        end
      end
    end else if (state_q == S_RESOLVE) begin
      pub_cnt_q[idx_q] <= rcnt;
      for (int k = 0; k < 4; k++) begin
        pub_x_q[idx_q][k] <= rx[k];
        pub_y_q[idx_q][k] <= ry[k];
      end
    end
  end

  always_comb begin
    corner_x = '0;
    corner_y = '0;
    pix_count = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pix_count[c*20 +: 20] = pub_cnt_q[c];
      for (int k = 0; k < 4; k++) begin
        corner_x[(c*4+k)*COORD_W +: COORD_W] = pub_x_q[c][k];
        corner_y[(c*4+k)*COORD_W +: COORD_W] = pub_y_q[c][k];
      end
    end
  end

  assign we = we_q;
  assign hist_out = hist_q;
  assign corner_code = code_q;
  assign frame_valid = fv_q;
  assign busy = (state_q == S_RESOLVE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_blob_corner_tracker.sv
// tb_blob_corner_tracker: scoreboard bench for blob_corner_tracker.
// Pixel and frame expectations are queued at stimulus time, popped on we/frame_valid.
module tb_blob_corner_tracker;

  localparam int NC = 2;
  localparam int HW = 4;
  localparam int CW = 10;
  localparam int TL = 0;
  localparam int TR = 1;
  localparam int BL = 2;
  localparam int BR = 3;
  localparam logic [7:0] C0 = 8'd110;
  localparam logic [7:0] C1 = 8'd210;

  typedef struct packed {
    logic [7:0] hist;
    logic [5:0] code;
  } pexp_t;

  typedef struct packed {
    logic [79:0] cx;
    logic [79:0] cy;
    logic [39:0] cnt;
  } fexp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic VGA_VS = 1'b1;
  logic pix_valid = 1'b0;
  logic [CW-1:0] pix_x = '0;
  logic [CW-1:0] pix_y = '0;
  logic [7:0] Cb = '0;
  logic [7:0] Cr = '0;
  logic [NC*HW-1:0] hist_in = '0;
  logic [NC*8-1:0] cb_lo = {8'd200, 8'd100};
  logic [NC*8-1:0] cb_hi = {8'd220, 8'd120};
  logic [NC*8-1:0] cr_lo = {8'd200, 8'd100};
  logic [NC*8-1:0] cr_hi = {8'd220, 8'd120};
  logic [NC*4-1:0] hist_thresh = {4'd2, 4'd2};
  logic [7:0] threshold_x_diff = 8'd2;
  logic [7:0] threshold_y_diff = 8'd2;

  logic [NC*HW-1:0] hist_out;
  logic we;
  logic [NC*3-1:0] corner_code;
  logic [NC*4*CW-1:0] corner_x;
  logic [NC*4*CW-1:0] corner_y;
  logic [NC*20-1:0] pix_count;
  logic frame_valid;
  logic busy;
  logic overrun;

  blob_corner_tracker dut (
    .clk(clk), .reset(reset), .VGA_VS(VGA_VS),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .Cb(Cb), .Cr(Cr), .hist_in(hist_in),
    .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo), .cr_hi(cr_hi),
    .hist_thresh(hist_thresh),
    .threshold_x_diff(threshold_x_diff),
    .threshold_y_diff(threshold_y_diff),
    .hist_out(hist_out), .we(we), .corner_code(corner_code),
    .corner_x(corner_x), .corner_y(corner_y),
    .pix_count(pix_count), .frame_valid(frame_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  pexp_t pq[$];
  fexp_t fq[$];
  fexp_t ef;
  pexp_t pe;
  fexp_t fe;
  int n_chk = 0;
  int n_fail = 0;
  int n_fv = 0;

  task automatic check(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hist_model(input logic [7:0] cb,
                                            input logic [7:0] cr,
                                            input logic [7:0] h);
    logic [7:0] r;
    logic m;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      m = (cb >= cb_lo[c*8 +: 8]) && (cb <= cb_hi[c*8 +: 8]) &&
          (cr >= cr_lo[c*8 +: 8]) && (cr <= cr_hi[c*8 +: 8]);
      r[c*4 +: 4] = {h[c*4 +: 3], m};
    end
    return r;
  endfunction

  task automatic px(input int x, input int y, input logic [7:0] cb,
                    input logic [7:0] cr, input logic [7:0] h,
                    input logic [5:0] code);
    pexp_t e;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_x = CW'(x);
    pix_y = CW'(y);
    Cb = cb;
    Cr = cr;
    hist_in = h;
    e.hist = hist_model(cb, cr, h);
    e.code = code;
    pq.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic setc(input int c, input int k, input int x, input int y);
    ef.cx[(c*4+k)*CW +: CW] = CW'(x);
    ef.cy[(c*4+k)*CW +: CW] = CW'(y);
  endtask

  task automatic setn(input int c, input int n);
    ef.cnt[c*20 +: 20] = 20'(n);
  endtask

  task automatic vs_edge();
    @(negedge clk);
    VGA_VS = 1'b0;
    pix_valid = 1'b0;
    fq.push_back(ef);
    @(negedge clk);
    VGA_VS = 1'b1;
    check("busy_r0", 80'(busy), 80'd1);
    @(negedge clk);
    check("busy_r1", 80'(busy), 80'd1);
    @(negedge clk);
    check("busy_done", 80'(busy), 80'd0);
    check("fv_pulse", 80'(frame_valid), 80'd1);
    @(negedge clk);
    check("fv_single", 80'(frame_valid), 80'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (we) begin
        if (pq.size() == 0) begin
          check("we_extra", 80'(we), 80'd0);
        end else begin
          pe = pq.pop_front();
          check("hist_out", 80'(hist_out), 80'(pe.hist));
          check("corner_code", 80'(corner_code), 80'(pe.code));
        end
      end
      if (frame_valid) begin
        n_fv++;
        if (fq.size() == 0) begin
          check("fv_extra", 80'(frame_valid), 80'd0);
        end else begin
          fe = fq.pop_front();
          for (int c = 0; c < NC; c++) begin
            check($sformatf("cx_ch%0d", c), 80'(corner_x[c*40 +: 40]),
                  80'(fe.cx[c*40 +: 40]));
            check($sformatf("cy_ch%0d", c), 80'(corner_y[c*40 +: 40]),
                  80'(fe.cy[c*40 +: 40]));
            check($sformatf("cnt_ch%0d", c), 80'(pix_count[c*20 +: 20]),
                  80'(fe.cnt[c*20 +: 20]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_we", 80'(we), 80'd0);
    check("rst_fv", 80'(frame_valid), 80'd0);
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_ovr", 80'(overrun), 80'd0);
    check("rst_hist", 80'(hist_out), 80'd0);
    check("rst_code", 80'(corner_code), 80'd0);
    check("rst_cx", corner_x, 80'd0);
    check("rst_cnt", 80'(pix_count), 80'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Frame A: diamond on ch0, ch1 empty, plus rejected pixels.
    px(100, 50, C0, C0, 8'hFF, 6'o05);
    px(150, 100, C0, C0, 8'hFF, 6'o05);
    px(100, 150, C0, C0, 8'hFF, 6'o05);
    px(50, 100, C0, C0, 8'hFF, 6'o05);
    px(30, 30, C0, C0, 8'hF3, 6'o00);
    px(700, 10, C0, C0, 8'hFF, 6'o00);
    px(10, 600, C0, C0, 8'hFF, 6'o00);
    idle();
    ef = '0;
    setc(0, TL, 50, 100);
    setc(0, TR, 100, 50);
    setc(0, BL, 100, 150);
    setc(0, BR, 150, 100);
    setn(0, 4);
    vs_edge();
    check("ovr_a", 80'(overrun), 80'd0);

    // Frame B: revisit published corners; one ch1 pixel.
    px(50, 100, C0, C0, 8'hFF, 6'o01);
    px(150, 100, C0, C0, 8'hFF, 6'o04);
    px(100, 50, C0, C0, 8'hFF, 6'o02);
    px(5, 5, C1, C1, 8'hFF, 6'o50);
    idle();
    ef = '0;
    setc(0, TL, 50, 100);
    setc(0, TR, 100, 50);
`ifdef CORNER_SNAP_EN
    setc(0, BL, 50, 100);
`else
    setc(0, BL, 150, 100);
`endif
    setc(0, BR, 150, 100);
    setn(0, 3);
    for (int k = 0; k < 4; k++) setc(1, k, 5, 5);
    setn(1, 1);
    vs_edge();

    // Frame C: square corners, closed by a double VS edge.
    px(20, 20, C0, C0, 8'hFF, 6'o05);
    px(10, 20, C0, C0, 8'hFF, 6'o05);
    px(20, 10, C0, C0, 8'hFF, 6'o05);
    px(10, 10, C0, C0, 8'hFF, 6'o05);
    idle();
    ef = '0;
`ifdef CORNER_SNAP_EN
    setc(0, TL, 10, 10);
    setc(0, TR, 20, 10);
    setc(0, BL, 10, 20);
    setc(0, BR, 20, 20);
`else
    setc(0, TL, 10, 10);
    setc(0, TR, 10, 10);
    setc(0, BL, 10, 20);
    setc(0, BR, 20, 10);
`endif
    setn(0, 4);
    fq.push_back(ef);
    px(400, 400, C0, C0, 8'hFF, 6'o05);
    VGA_VS = 1'b0;
    px(300, 200, C0, C0, 8'hFF, 6'o05);
    VGA_VS = 1'b1;
    check("busy_dbl", 80'(busy), 80'd1);
    @(negedge clk);
    VGA_VS = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    VGA_VS = 1'b1;
    check("ovr_set", 80'(overrun), 80'd1);
    check("fv_dbl", 80'(frame_valid), 80'd1);
    repeat (3) @(negedge clk);

    // Frame D: only the pixel seen during resolve belongs here.
    ef = '0;
    for (int k = 0; k < 4; k++) setc(0, k, 300, 200);
    setn(0, 1);
    vs_edge();
    check("ovr_sticky", 80'(overrun), 80'd1);

    // Reset while resolving aborts the publish.
    px(1, 1, C0, C0, 8'hFF, 6'o05);
    idle();
    @(negedge clk);
    VGA_VS = 1'b0;
    @(negedge clk);
    VGA_VS = 1'b1;
    check("busy_abort", 80'(busy), 80'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 80'(busy), 80'd0);
    check("abort_cx", corner_x, 80'd0);
    check("abort_cy", corner_y, 80'd0);
    check("abort_cnt", 80'(pix_count), 80'd0);
    check("abort_ovr", 80'(overrun), 80'd0);
    repeat (6) @(negedge clk);

    check("pq_left", 80'(pq.size()), 80'd0);
    check("fq_left", 80'(fq.size()), 80'd0);
    check("fv_total", 80'(n_fv), 80'd4);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
